// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master bus arbiter with turnaround cycle, alternating tie-break and tenure limit
module bus_arbiter #(
    parameter int TENURE_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       busreq_1,
    input  logic       busreq_2,
    output logic       grant_1,
    output logic       grant_2,
    output logic       bus_busy,
    output logic [1:0] owner,
    output logic       timeout
);
    localparam int CW = $clog2(TENURE_MAX + 1);
    localparam logic [CW-1:0] TM = CW'(TENURE_MAX);

    typedef enum logic [1:0] {IDLE, GNT1, GNT2, TURN} state_t;

    state_t        state, next_state, arb;
    logic          last_owner;
    logic [CW-1:0] cnt;
    logic          expire;

    // arbitration result for IDLE/TURN and next-state selection
    always_comb begin
        next_state = state;
        expire = 1'b0;
        arb = (busreq_1 && busreq_2) ? (last_owner ? GNT1 : GNT2) :
              busreq_1 ? GNT1 : busreq_2 ? GNT2 : IDLE;
        case (state)
            IDLE, TURN: next_state = arb;
            GNT1: begin
                if (!busreq_1) next_state = TURN;
                else if (cnt == TM && busreq_2) begin
                    next_state = TURN;
                    expire = 1'b1;
                end
            end
            GNT2: begin
                if (!busreq_2) next_state = TURN;
                else if (cnt == TM && busreq_1) begin
                    next_state = TURN;
                    expire = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // state, tenure counter, tie-break memory and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            last_owner <= 1'b1;
            timeout <= 1'b0;
            grant_1 <= 1'b0;
            grant_2 <= 1'b0;
            bus_busy <= 1'b0;
            owner <= 2'b00;
        end else begin
            state <= next_state;
            timeout <= expire;
            grant_1 <= next_state == GNT1;
            grant_2 <= next_state == GNT2;
            bus_busy <= next_state == GNT1 || next_state == GNT2;
            owner <= {next_state == GNT2, next_state == GNT1};
            if (next_state == GNT1 || next_state == GNT2) begin
                cnt <= (next_state != state) ? CW'(1) : (cnt == TM) ? cnt : cnt + CW'(1);
                if (next_state != state) last_owner <= next_state == GNT2;
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: TENURE_MAX, default 8, maximum contended grant tenure in cycles; legal range 2..255.
REQ-002 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset; sampled on rising edge of clk only.
REQ-004 Port: busreq_1  input  1  bus request from master 1, level, held while master wants the bus.
REQ-005 Port: busreq_2  input  1  bus request from master 2, same rules as busreq_1.
REQ-006 Port: grant_1  output  1  bus grant to master 1, registered.
REQ-007 Port: grant_2  output  1  bus grant to master 2, registered.
REQ-008 Port: bus_busy  output  1  high whenever grant_1 or grant_2 is high, registered.
REQ-009 Port: owner  output  2  current owner: 2'b00 none, 2'b01 master 1, 2'b10 master 2; registered.
REQ-010 Port: timeout  output  1  one-cycle pulse when a grant is revoked by tenure expiry.

Function
REQ-011 The FSM SHALL have four states: IDLE, GNT1, GNT2, TURN; encoding is free.
REQ-012 grant_1 SHALL be high iff state is GNT1; grant_2 iff GNT2; the two SHALL never be high in the same cycle.
REQ-013 In IDLE or TURN, the requests sampled at an edge SHALL decide the next state: none -> IDLE; one -> that master's GNT state; both -> the GNT state of the master that is not last_owner.
REQ-014 last_owner SHALL be a 1-bit register updated to the granted master on every entry to GNT1/GNT2.
REQ-015 Grant latency SHALL be exactly one cycle: a request sampled at edge k in IDLE/TURN gives a grant visible from edge k+1.
REQ-016 In GNTx, a deasserted busreq_x sampled at an edge SHALL move the FSM to TURN.
REQ-017 TURN SHALL last exactly one cycle with both grants low (bus turnaround), then arbitrate per REQ-013.
REQ-018 A tenure counter, width clog2(TENURE_MAX+1), SHALL load 1 on entry to GNTx, increment each further GNTx cycle, and saturate at TENURE_MAX.
REQ-019 In GNTx with counter == TENURE_MAX, busreq_x still high and the other request high, the FSM SHALL go to TURN, and timeout SHALL be high for that one TURN cycle.
REQ-020 Without a competing request the owner SHALL keep the grant indefinitely; the counter stays saturated and no timeout is raised.
REQ-021 If the owner drops its request in the same cycle the tenure expires, the transition SHALL be an ordinary release: TURN with timeout low.
REQ-022 A revoked master that keeps requesting SHALL be re-granted only after the other master's tenure ends, per REQ-013.
REQ-023 bus_busy and owner SHALL be consistent with grant_1/grant_2 in every cycle.

Reset
REQ-024 With rst high at an edge, the next state SHALL be IDLE, and grant_1, grant_2, bus_busy and timeout SHALL be 0, owner 2'b00, counter 0, and last_owner master 2, so master 1 wins the first tie.
REQ-025 Reset SHALL take priority over every other transition, including mid-grant and during TURN; the grant SHALL drop in the cycle after reset is sampled.
REQ-026 Outputs SHALL be X-free from the first edge at which rst is sampled high.

Verification
REQ-027 Reset, then busreq_1=1 only -> grant_1=1 and owner=01 one cycle later; hold 20 cycles -> grant held, timeout never 1.
REQ-028 From IDLE, busreq_1 and busreq_2 asserted at the same edge after reset -> grant_1 first; busreq_1 dropped -> one TURN cycle with both grants 0, then grant_2=1, owner=10.
REQ-029 TENURE_MAX=8; both masters request continuously -> grant_1 high exactly 8 cycles, 1 TURN cycle with timeout=1, then grant_2 for 8 cycles, then TURN; pattern repeats; grants never overlap.
REQ-030 Owner busreq_2 drops at the expiry cycle while busreq_1 is high -> TURN with timeout=0, then grant_1.
REQ-031 rst asserted for one cycle mid-GNT2 with both requests high -> all outputs 0 the next cycle, then grant_1 (tie goes to master 1).
REQ-032 Random request stimulus, 10k cycles -> grant_1 and grant_2 never both high, bus_busy == grant_1|grant_2, and every grant is preceded by a TURN or IDLE cycle.
